// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the MIPS multicycle main-control sequencer.
package mips_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_WRITEBACK = 3'd3,
        S_EXCEPT    = 3'd4
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_ANDI  = 6'd12;

    localparam logic [5:0] FN_SLL = 6'd0;
    localparam logic [5:0] FN_SRL = 6'd2;
    localparam logic [5:0] FN_SRA = 6'd3;
    localparam logic [5:0] FN_ADD = 6'd32;
    localparam logic [5:0] FN_SUB = 6'd34;
    localparam logic [5:0] FN_AND = 6'd36;
    localparam logic [5:0] FN_OR  = 6'd37;
    localparam logic [5:0] FN_SLT = 6'd42;

    localparam logic [1:0] ALUOP_ADD   = 2'd0;
    localparam logic [1:0] ALUOP_AND   = 2'd1;
    localparam logic [1:0] ALUOP_FUNCT = 2'd2;

    localparam logic [1:0] EXC_NONE  = 2'd0;
    localparam logic [1:0] EXC_OVF   = 2'd1;
    localparam logic [1:0] EXC_OPC   = 2'd2;
    localparam logic [1:0] EXC_FUNCT = 2'd3;

    function automatic logic funct_legal(input logic [5:0] f);
        case (f)
            FN_SLL, FN_SRL, FN_SRA, FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_main_control_fsm_if.sv
// Instruction handshake, ALU-control, writeback and exception signals of the sequencer.
interface mips_main_control_fsm_if #(
    parameter int CNT_W = 16
);
    logic             instr_valid;
    logic             instr_ready;
    logic [31:0]      instr;
    logic [1:0]       alu_op;
    logic [5:0]       alu_funct;
    logic             alu_src_imm;
    logic [31:0]      imm_ext;
    logic             alu_overflow;
    logic             reg_write;
    logic [4:0]       wb_reg;
    logic             done;
    logic [CNT_W-1:0] retired_count;
    logic             exc_valid;
    logic [1:0]       exc_code;
    logic [5:0]       exc_opcode;
    logic             exc_ack;

    modport master (
        output instr_valid, instr, alu_overflow, exc_ack,
        input  instr_ready, alu_op, alu_funct, alu_src_imm, imm_ext,
               reg_write, wb_reg, done, retired_count,
               exc_valid, exc_code, exc_opcode
    );

    modport slave (
        input  instr_valid, instr, alu_overflow, exc_ack,
        output instr_ready, alu_op, alu_funct, alu_src_imm, imm_ext,
               reg_write, wb_reg, done, retired_count,
               exc_valid, exc_code, exc_opcode
    );
endinterface

// File: rtl/mips_instr_decode.sv
// Combinational decode of the latched instruction word into legality, ALU controls
// and writeback destination.
module mips_instr_decode
    import mips_ctrl_pkg::*;
(
    input  logic [31:0] ir,
    output logic        legal,
    output logic [1:0]  exc_code,
    output logic [1:0]  alu_op,
    output logic        alu_src_imm,
    output logic [31:0] imm_ext,
    output logic [4:0]  wb_reg,
    output logic        ovf_chk
);
    logic [5:0] opcode;
    logic [5:0] funct;
    wire        unused_rs = ^ir[25:21];

    assign opcode = ir[31:26];
    assign funct  = ir[5:0];

    always_comb begin
        legal       = 1'b0;
        exc_code    = EXC_OPC;
        alu_op      = ALUOP_ADD;
        alu_src_imm = 1'b0;
        imm_ext     = 32'd0;
        wb_reg      = ir[20:16];
        ovf_chk     = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                legal    = funct_legal(funct);
                exc_code = funct_legal(funct) ? EXC_NONE : EXC_FUNCT;
                alu_op   = ALUOP_FUNCT;
                wb_reg   = ir[15:11];
                ovf_chk  = (funct == FN_ADD) || (funct == FN_SUB);
            end
            OP_ADDI: begin
                legal       = 1'b1;
                exc_code    = EXC_NONE;
                alu_src_imm = 1'b1;
                imm_ext     = {{16{ir[15]}}, ir[15:0]};
                ovf_chk     = 1'b1;
            end
            OP_ANDI: begin
                legal       = 1'b1;
                exc_code    = EXC_NONE;
                alu_op      = ALUOP_AND;
                alu_src_imm = 1'b1;
                imm_ext     = {16'd0, ir[15:0]};
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/mips_main_control_fsm.sv
// Multicycle main-control sequencer: accept -> decode -> execute -> writeback/except.
// Every output is a register; the decoder only looks at the latched IR.
module mips_main_control_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter bit OVF_TRAP_EN = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    mips_main_control_fsm_if.slave bus
);
    state_t           state_reg;
    logic [31:0]      ir_reg;
    logic             instr_ready_reg;
    logic [1:0]       alu_op_reg;
    logic [5:0]       alu_funct_reg;
    logic             alu_src_imm_reg;
    logic [31:0]      imm_ext_reg;
    logic             reg_write_reg;
    logic [4:0]       wb_reg_reg;
    logic             done_reg;
    logic [CNT_W-1:0] retired_count_reg;
    logic             exc_valid_reg;
    logic [1:0]       exc_code_reg;
    logic [5:0]       exc_opcode_reg;

    logic        dec_legal;
    logic [1:0]  dec_exc_code;
    logic [1:0]  dec_alu_op;
    logic        dec_alu_src_imm;
    logic [31:0] dec_imm_ext;
    logic [4:0]  dec_wb_reg;
    logic        dec_ovf_chk;

    mips_instr_decode u_decode (
        .ir          (ir_reg),
        .legal       (dec_legal),
        .exc_code    (dec_exc_code),
        .alu_op      (dec_alu_op),
        .alu_src_imm (dec_alu_src_imm),
        .imm_ext     (dec_imm_ext),
        .wb_reg      (dec_wb_reg),
        .ovf_chk     (dec_ovf_chk)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg         <= S_IDLE;
            ir_reg            <= 32'd0;
            instr_ready_reg   <= 1'b1;
            alu_op_reg        <= 2'd0;
            alu_funct_reg     <= 6'd0;
            alu_src_imm_reg   <= 1'b0;
            imm_ext_reg       <= 32'd0;
            reg_write_reg     <= 1'b0;
            wb_reg_reg        <= 5'd0;
            done_reg          <= 1'b0;
            retired_count_reg <= '0;
            exc_valid_reg     <= 1'b0;
            exc_code_reg      <= 2'd0;
            exc_opcode_reg    <= 6'd0;
        end else begin
            reg_write_reg <= 1'b0;
            wb_reg_reg    <= 5'd0;
            done_reg      <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (bus.instr_valid) begin
                        ir_reg          <= bus.instr;
                        instr_ready_reg <= 1'b0;
                        state_reg       <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (dec_legal) begin
                        alu_op_reg      <= dec_alu_op;
                        alu_funct_reg   <= ir_reg[5:0];
                        alu_src_imm_reg <= dec_alu_src_imm;
                        imm_ext_reg     <= dec_imm_ext;
                        state_reg       <= S_EXECUTE;
                    end else begin
                        exc_valid_reg  <= 1'b1;
                        exc_code_reg   <= dec_exc_code;
                        exc_opcode_reg <= ir_reg[31:26];
                        state_reg      <= S_EXCEPT;
                    end
                end
                S_EXECUTE: begin
                    state_reg <= S_WRITEBACK;
                end
                S_WRITEBACK: begin
                    alu_op_reg      <= 2'd0;
                    alu_funct_reg   <= 6'd0;
                    alu_src_imm_reg <= 1'b0;
                    imm_ext_reg     <= 32'd0;
                    if (OVF_TRAP_EN && bus.alu_overflow && dec_ovf_chk) begin
                        exc_valid_reg  <= 1'b1;
                        exc_code_reg   <= EXC_OVF;
                        exc_opcode_reg <= ir_reg[31:26];
                        state_reg      <= S_EXCEPT;
                    end else begin
                        // Writes to $0 are dropped, but the instruction still retires.
                        done_reg          <= 1'b1;
                        reg_write_reg     <= (dec_wb_reg != 5'd0);
                        wb_reg_reg        <= dec_wb_reg;
                        retired_count_reg <= retired_count_reg + CNT_W'(1);
                        instr_ready_reg   <= 1'b1;
                        state_reg         <= S_IDLE;
                    end
                end
                S_EXCEPT: begin
                    if (bus.exc_ack) begin
                        exc_valid_reg   <= 1'b0;
                        exc_code_reg    <= 2'd0;
                        exc_opcode_reg  <= 6'd0;
                        instr_ready_reg <= 1'b1;
                        state_reg       <= S_IDLE;
                    end
                end
                default: begin
                    instr_ready_reg <= 1'b1;
                    state_reg       <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.instr_ready   = instr_ready_reg;
    assign bus.alu_op        = alu_op_reg;
    assign bus.alu_funct     = alu_funct_reg;
    assign bus.alu_src_imm   = alu_src_imm_reg;
    assign bus.imm_ext       = imm_ext_reg;
    assign bus.reg_write     = reg_write_reg;
    assign bus.wb_reg        = wb_reg_reg;
    assign bus.done          = done_reg;
    assign bus.retired_count = retired_count_reg;
    assign bus.exc_valid     = exc_valid_reg;
    assign bus.exc_code      = exc_code_reg;
    assign bus.exc_opcode    = exc_opcode_reg;
endmodule

// File: tb/tb_mips_main_control_fsm.sv
// Self-checking bench: two controllers (trapping 16-bit counter, non-trapping 3-bit
// counter) against a transaction-level model, plus directed literal checks.
module tb_mips_main_control_fsm;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    mips_main_control_fsm_if #(.CNT_W(16)) ia ();
    mips_main_control_fsm_if #(.CNT_W(3))  ib ();

    mips_main_control_fsm #(.CNT_W(16), .OVF_TRAP_EN(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(ia));
    mips_main_control_fsm #(.CNT_W(3),  .OVF_TRAP_EN(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(ib));

    typedef struct {
        logic        ready;
        logic [1:0]  alu_op;
        logic [5:0]  funct;
        logic        src;
        logic [31:0] imm;
        logic        rw;
        logic [4:0]  wb;
        logic        done;
        logic [31:0] cnt;
        logic        exc_v;
        logic [1:0]  exc_c;
        logic [5:0]  exc_o;
    } obs_t;

    // Model state: phase counts cycles since accept (0 = waiting for an instruction).
    obs_t        m_exp   [2];
    int          m_phase [2];
    bit          m_exc   [2];
    logic [31:0] m_cur   [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s got=%08h want=%08h t=%0t", name, act, want, $time);
        end
    endtask

    task automatic mreset(input int k);
        m_exp[k] = '{ready: 1'b1, alu_op: 2'd0, funct: 6'd0, src: 1'b0, imm: 32'd0,
                     rw: 1'b0, wb: 5'd0, done: 1'b0, cnt: 32'd0,
                     exc_v: 1'b0, exc_c: 2'd0, exc_o: 6'd0};
        m_phase[k] = 0;
        m_exc[k]   = 0;
        m_cur[k]   = 32'd0;
    endtask

    task automatic mstep(input int k, input logic v, input logic [31:0] w, input logic ovf,
                         input logic ack, input bit trap, input int cw);
        logic [5:0] op;
        logic [5:0] f;
        op = m_cur[k][31:26];
        f  = m_cur[k][5:0];
        m_exp[k].done = 1'b0;
        m_exp[k].rw   = 1'b0;
        m_exp[k].wb   = 5'd0;
        if (m_exc[k]) begin
            if (ack) begin
                m_exc[k] = 0;
                m_exp[k].exc_v = 1'b0; m_exp[k].exc_c = 2'd0; m_exp[k].exc_o = 6'd0;
                m_exp[k].ready = 1'b1;
            end
        end else if (m_phase[k] == 0) begin
            if (v) begin
                m_cur[k] = w; m_phase[k] = 1; m_exp[k].ready = 1'b0;
            end
        end else if (m_phase[k] == 1) begin
            if ((op == 6'd0 && f inside {6'd0, 6'd2, 6'd3, 6'd32, 6'd34, 6'd36, 6'd37, 6'd42})
                || op == 6'd8 || op == 6'd12) begin
                m_phase[k]      = 2;
                m_exp[k].alu_op = (op == 6'd0) ? 2'd2 : (op == 6'd8) ? 2'd0 : 2'd1;
                m_exp[k].funct  = f;
                m_exp[k].src    = (op != 6'd0);
                m_exp[k].imm    = (op == 6'd8)  ? {{16{m_cur[k][15]}}, m_cur[k][15:0]} :
                                  (op == 6'd12) ? {16'd0, m_cur[k][15:0]} : 32'd0;
            end else begin
                m_phase[k] = 0; m_exc[k] = 1;
                m_exp[k].exc_v = 1'b1;
                m_exp[k].exc_c = (op == 6'd0) ? 2'd3 : 2'd2;
                m_exp[k].exc_o = op;
            end
        end else if (m_phase[k] == 2) begin
            m_phase[k] = 3;
        end else begin
            m_phase[k] = 0;
            m_exp[k].alu_op = 2'd0; m_exp[k].funct = 6'd0; m_exp[k].src = 1'b0; m_exp[k].imm = 32'd0;
            if (trap && ovf && ((op == 6'd0 && (f == 6'd32 || f == 6'd34)) || op == 6'd8)) begin
                m_exc[k] = 1;
                m_exp[k].exc_v = 1'b1; m_exp[k].exc_c = 2'd1; m_exp[k].exc_o = op;
            end else begin
                m_exp[k].done  = 1'b1;
                m_exp[k].cnt   = (m_exp[k].cnt + 1) % (32'd1 << cw);
                m_exp[k].wb    = (op == 6'd0) ? m_cur[k][15:11] : m_cur[k][20:16];
                m_exp[k].rw    = (m_exp[k].wb != 5'd0);
                m_exp[k].ready = 1'b1;
            end
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mreset(0);
            mreset(1);
        end else begin
            mstep(0, ia.instr_valid, ia.instr, ia.alu_overflow, ia.exc_ack, 1'b1, 16);
            mstep(1, ib.instr_valid, ib.instr, ib.alu_overflow, ib.exc_ack, 1'b0, 3);
        end
    end

    task automatic cmp_all(input int k, input obs_t a);
        string p;
        p = (k == 0) ? "A" : "B";
        chk({p, ".instr_ready"},   32'(a.ready),  32'(m_exp[k].ready));
        chk({p, ".alu_op"},        32'(a.alu_op), 32'(m_exp[k].alu_op));
        chk({p, ".alu_funct"},     32'(a.funct),  32'(m_exp[k].funct));
        chk({p, ".alu_src_imm"},   32'(a.src),    32'(m_exp[k].src));
        chk({p, ".imm_ext"},       a.imm,         m_exp[k].imm);
        chk({p, ".reg_write"},     32'(a.rw),     32'(m_exp[k].rw));
        chk({p, ".wb_reg"},        32'(a.wb),     32'(m_exp[k].wb));
        chk({p, ".done"},          32'(a.done),   32'(m_exp[k].done));
        chk({p, ".retired_count"}, a.cnt,         m_exp[k].cnt);
        chk({p, ".exc_valid"},     32'(a.exc_v),  32'(m_exp[k].exc_v));
        chk({p, ".exc_code"},      32'(a.exc_c),  32'(m_exp[k].exc_c));
        chk({p, ".exc_opcode"},    32'(a.exc_o),  32'(m_exp[k].exc_o));
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_all(0, '{ia.instr_ready, ia.alu_op, ia.alu_funct, ia.alu_src_imm, ia.imm_ext,
                         ia.reg_write, ia.wb_reg, ia.done, 32'(ia.retired_count),
                         ia.exc_valid, ia.exc_code, ia.exc_opcode});
            cmp_all(1, '{ib.instr_ready, ib.alu_op, ib.alu_funct, ib.alu_src_imm, ib.imm_ext,
                         ib.reg_write, ib.wb_reg, ib.done, 32'(ib.retired_count),
                         ib.exc_valid, ib.exc_code, ib.exc_opcode});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [31:0] w);
        int n = 0;
        while (ia.instr_ready !== 1'b1 && n < 20) begin tick(); n++; end
        if (n >= 20) chk("A.ready_wait", 32'(ia.instr_ready), 32'd1);
        $display("txn A instr=%08h", w);
        ia.instr_valid = 1'b1; ia.instr = w;
        tick();
        ia.instr_valid = 1'b0;
    endtask

    // Runs one instruction on B; returns in the cycle after WRITEBACK.
    task automatic run_b(input logic [31:0] w, input logic ovf);
        int n = 0;
        while (ib.instr_ready !== 1'b1 && n < 20) begin tick(); n++; end
        if (n >= 20) chk("B.ready_wait", 32'(ib.instr_ready), 32'd1);
        $display("txn B instr=%08h ovf=%0d", w, ovf);
        ib.instr_valid = 1'b1; ib.instr = w;
        tick();
        ib.instr_valid = 1'b0;
        tick();
        ib.alu_overflow = ovf;
        tick();
        tick();
        ib.alu_overflow = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] legal_f [8];
        logic [5:0] op;
        logic [5:0] fn;
        logic [4:0] rt;
        logic [4:0] rd;
        int s;
        legal_f = '{6'd0, 6'd2, 6'd3, 6'd32, 6'd34, 6'd36, 6'd37, 6'd42};
        s  = int'($urandom_range(0, 7));
        op = (s < 3) ? 6'd0 : (s < 5) ? 6'd8 : (s == 5) ? 6'd12 : 6'($urandom);
        fn = ($urandom_range(0, 3) != 0) ? legal_f[$urandom_range(0, 7)] : 6'($urandom);
        rt = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        return {op, 5'($urandom), rt, rd, 5'($urandom), fn};
    endfunction

    initial begin
        rst = 1'b1;
        ia.instr_valid = 0; ia.instr = 0; ia.alu_overflow = 0; ia.exc_ack = 0;
        ib.instr_valid = 0; ib.instr = 0; ib.alu_overflow = 0; ib.exc_ack = 0;
        tick();
        chk_en = 1;
        chk("A.reset_ready", 32'(ia.instr_ready), 32'd1);
        chk("A.reset_count", 32'(ia.retired_count), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // ADDI $5, 0xFFFF
        send_a({6'd8, 5'd0, 5'd5, 16'hFFFF});
        tick();
        chk("addi.alu_op", 32'(ia.alu_op), 32'd0);
        chk("addi.imm_ext", ia.imm_ext, 32'hFFFF_FFFF);
        chk("addi.src_imm", 32'(ia.alu_src_imm), 32'd1);
        tick(); tick();
        chk("addi.reg_write", 32'(ia.reg_write), 32'd1);
        chk("addi.wb_reg", 32'(ia.wb_reg), 32'd5);
        chk("addi.done", 32'(ia.done), 32'd1);
        chk("addi.count", 32'(ia.retired_count), 32'd1);

        // ANDI $3, 0x8001
        send_a({6'd12, 5'd0, 5'd3, 16'h8001});
        tick();
        chk("andi.imm_ext", ia.imm_ext, 32'h0000_8001);
        chk("andi.alu_op", 32'(ia.alu_op), 32'd1);
        tick(); tick();
        chk("andi.count", 32'(ia.retired_count), 32'd2);

        // SUB rd=7 overflowing
        send_a({6'd0, 5'd1, 5'd2, 5'd7, 5'd0, 6'd34});
        tick();
        chk("sub.alu_op", 32'(ia.alu_op), 32'd2);
        ia.alu_overflow = 1'b1;
        tick(); tick();
        ia.alu_overflow = 1'b0;
        chk("sub.reg_write", 32'(ia.reg_write), 32'd0);
        chk("sub.exc_valid", 32'(ia.exc_valid), 32'd1);
        chk("sub.exc_code", 32'(ia.exc_code), 32'd1);
        chk("sub.exc_opcode", 32'(ia.exc_opcode), 32'd0);
        ia.exc_ack = 1'b1;
        tick();
        ia.exc_ack = 1'b0;
        chk("sub.ready_after_ack", 32'(ia.instr_ready), 32'd1);
        chk("sub.exc_cleared", 32'(ia.exc_valid), 32'd0);

        // Illegal opcode 35
        send_a({6'd35, 26'h0012345});
        tick();
        chk("op35.exc_code", 32'(ia.exc_code), 32'd2);
        chk("op35.exc_opcode", 32'(ia.exc_opcode), 32'd35);
        chk("op35.no_execute", 32'(ia.alu_src_imm), 32'd0);
        ia.exc_ack = 1'b1; tick(); ia.exc_ack = 1'b0;

        // Illegal funct 8
        send_a({6'd0, 5'd1, 5'd2, 5'd9, 5'd0, 6'd8});
        tick();
        chk("funct8.exc_code", 32'(ia.exc_code), 32'd3);
        ia.exc_ack = 1'b1; tick(); ia.exc_ack = 1'b0;
        chk("illegal.count", 32'(ia.retired_count), 32'd2);

        // SLL $0
        send_a(32'd0);
        tick(); tick(); tick();
        chk("sll0.done", 32'(ia.done), 32'd1);
        chk("sll0.reg_write", 32'(ia.reg_write), 32'd0);
        chk("sll0.count", 32'(ia.retired_count), 32'd3);

        // Async reset in EXECUTE
        send_a({6'd8, 5'd0, 5'd9, 16'h0004});
        tick();
        chk("rst.pre_alu_src", 32'(ia.alu_src_imm), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("rst.async_ready", 32'(ia.instr_ready), 32'd1);
        chk("rst.async_count", 32'(ia.retired_count), 32'd0);
        chk("rst.async_imm", ia.imm_ext, 32'd0);
        chk("rst.async_src", 32'(ia.alu_src_imm), 32'd0);
        tick();
        rst = 1'b0;
        tick(); tick();
        chk("rst.no_done", 32'(ia.done), 32'd0);

        // Counter wrap on the 3-bit, non-trapping instance
        for (int i = 1; i <= 8; i++) begin
            run_b({6'd12, 5'd0, 5'(i), 16'h00F0}, 1'b0);
            if (i == 7) chk("wrap.count7", 32'(ib.retired_count), 32'd7);
        end
        chk("wrap.count0", 32'(ib.retired_count), 32'd0);
        run_b({6'd0, 5'd1, 5'd2, 5'd4, 5'd0, 6'd32}, 1'b1);
        chk("notrap.done", 32'(ib.done), 32'd1);
        chk("notrap.reg_write", 32'(ib.reg_write), 32'd1);
        chk("notrap.exc_valid", 32'(ib.exc_valid), 32'd0);
        chk("notrap.count", 32'(ib.retired_count), 32'd1);

        // Randomized traffic on both instances, checked by the model every cycle
        for (int c = 0; c < 3000; c++) begin
            ia.instr_valid  = ($urandom_range(0, 2) != 0);
            ia.instr        = rand_instr();
            ia.alu_overflow = ($urandom_range(0, 2) == 0);
            ia.exc_ack      = ($urandom_range(0, 2) == 0);
            ib.instr_valid  = ($urandom_range(0, 2) != 0);
            ib.instr        = rand_instr();
            ib.alu_overflow = ($urandom_range(0, 1) == 0);
            ib.exc_ack      = ($urandom_range(0, 2) == 0);
            tick();
        end
        ia.instr_valid = 0; ib.instr_valid = 0;
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
